io_regfile: RTL and testbench

Parametrised CPU register file with memory-mapped I/O channels. It supersedes the fixed three-input / one-output game register file. External level inputs are synchronised, and their rising edges are latched into a sticky, write-1-to-clear status register. Selected storage registers drive output buses with a one-cycle update strobe, and an optional write-to-read bypass is provided. It sits between the CPU decode/writeback stages and the game I/O (buttons, game status, VGA sprite coordinates).

---
 rtl/io_regfile_pkg.sv | 10 +
 rtl/in_sync_edge.sv | 14 +
 rtl/io_regfile.sv | 75 +++++++
 tb/tb_io_regfile.sv | 108 ++++++++++
 4 files changed

// File: rtl/io_regfile_pkg.sv
// io_regfile_pkg: default address map, address classes and the shared address classifier
package io_regfile_pkg;
  localparam int DEF_IN_BASE   = 1;
  localparam int DEF_EDGE_ADDR = 8;
  localparam int DEF_OUT_BASE  = 4;
  typedef enum logic [1:0] {ZERO, INPUT, EDGE, STORAGE} addr_class_e;
  function automatic addr_class_e classify(input int a, input int in_base, input int n_in, input int edge_addr);
    return a == 0 ? ZERO : (a >= in_base && a < in_base + n_in) ? INPUT : a == edge_addr ? EDGE : STORAGE;
  endfunction
endpackage

// File: rtl/in_sync_edge.sv
// in_sync_edge: two-flop synchroniser for one external level plus rising-edge detect
module in_sync_edge (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic in_raw,
  output logic sync,
  output logic rise
);
  logic s1, prev;
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) {s1, sync, prev} <= '0;
    else {s1, sync, prev} <= {in_raw, s1, sync};
  assign rise = sync & ~prev;
endmodule

// File: rtl/io_regfile.sv
// io_regfile: CPU register file with synchronised inputs, sticky W1C edge flags and output channels
module io_regfile import io_regfile_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int N_IN      = 3,
  parameter int IN_BASE   = DEF_IN_BASE,
  parameter int EDGE_ADDR = DEF_EDGE_ADDR,
  parameter int N_OUT     = 1,
  parameter int OUT_BASE  = DEF_OUT_BASE,
  parameter int BYPASS    = 1
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_W-1:0]       ctrl_writeReg,
  input  logic [DATA_W-1:0]       data_writeReg,
  input  logic [ADDR_W-1:0]       ctrl_readRegA,
  input  logic [ADDR_W-1:0]       ctrl_readRegB,
  output logic [DATA_W-1:0]       data_readRegA,
  output logic [DATA_W-1:0]       data_readRegB,
  input  logic [N_IN-1:0]         in_raw,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_update
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit LEGAL = N_IN >= 1 && N_IN <= DATA_W && N_OUT >= 1
    && IN_BASE > 0 && EDGE_ADDR > 0 && OUT_BASE > 0
    && IN_BASE + N_IN <= DEPTH && EDGE_ADDR < DEPTH && OUT_BASE + N_OUT <= DEPTH
    && (EDGE_ADDR < IN_BASE || EDGE_ADDR >= IN_BASE + N_IN)
    && (EDGE_ADDR < OUT_BASE || EDGE_ADDR >= OUT_BASE + N_OUT)
    && (IN_BASE + N_IN <= OUT_BASE || OUT_BASE + N_OUT <= IN_BASE);
  if (!LEGAL) begin : g_illegal
    $error("io_regfile: illegal address map parameters");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [N_IN-1:0] sync, rise, pend, clr;
  logic [DEPTH-1:0] in_bit;
  logic [N_OUT-1:0] hit;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  addr_class_e wcls;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    in_sync_edge u_ch (.clock(clock), .ctrl_reset(ctrl_reset), .in_raw(in_raw[i]), .sync(sync[i]), .rise(rise[i]));
  end
  assign wcls   = classify(int'(ctrl_writeReg), IN_BASE, N_IN, EDGE_ADDR);
  assign clr    = (ctrl_writeEnable && wcls == EDGE) ? data_writeReg[N_IN-1:0] : '0;
  assign in_bit = DEPTH'(sync) << IN_BASE;
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) mem <= '{default: '0};
    else if (ctrl_writeEnable && wcls == STORAGE) mem[ctrl_writeReg] <= data_writeReg;
  // rise is OR-ed in after the clear so a simultaneous new edge keeps the flag set
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) pend <= '0;
    else pend <= (pend & ~clr) | rise;
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_data[k*DATA_W +: DATA_W] = mem[ADDR_W'(OUT_BASE + k)];
    assign hit[k] = ctrl_writeEnable && ctrl_writeReg == ADDR_W'(OUT_BASE + k);
  end
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) out_update <= '0;
    else out_update <= hit;
  assign ra[0] = ctrl_readRegA;
  assign ra[1] = ctrl_readRegB;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    addr_class_e c;
    assign c = classify(int'(ra[p]), IN_BASE, N_IN, EDGE_ADDR);
    assign rd[p] = c == ZERO ? '0
                 : c == INPUT ? DATA_W'(in_bit[ra[p]])
                 : c == EDGE ? DATA_W'(pend)
                 : (BYPASS != 0 && ctrl_writeEnable && ctrl_writeReg == ra[p]) ? data_writeReg
                 : mem[ra[p]];
  end
  assign data_readRegA = rd[0];
  assign data_readRegB = rd[1];
endmodule

// File: tb/tb_io_regfile.sv
// tb_io_regfile: directed scoreboard bench for io_regfile (default, no-bypass and wide-sweep instances)
module tb_io_regfile;
  logic clock = 0, ctrl_reset = 0, we = 0;
  logic [4:0] wa = 0, ra = 0, rb = 0;
  logic [31:0] wd = 0;
  logic [2:0] in_raw = 0;
  logic [4:0] in_raw_sw = 0;
  logic [31:0] rda, rdb, nba, nbb, od, nod;
  logic [15:0] swa, swb;
  logic [47:0] sod;
  logic od_u, nod_u;
  logic [2:0] sod_u;
  int vectors = 0, errs = 0;
  typedef struct {string tag; logic [63:0] v;} exp_t;
  exp_t sb[$];
  io_regfile dut (.clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .data_readRegA(rda), .data_readRegB(rdb),
    .in_raw(in_raw), .out_data(od), .out_update(od_u));
  io_regfile #(.BYPASS(0)) dut_nb (.clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we),
    .ctrl_writeReg(wa), .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .data_readRegA(nba),
    .data_readRegB(nbb), .in_raw(in_raw), .out_data(nod), .out_update(nod_u));
  io_regfile #(.DATA_W(16), .N_IN(5), .N_OUT(3), .OUT_BASE(12)) dut_sw (.clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd[15:0]), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(swa), .data_readRegB(swb), .in_raw(in_raw_sw), .out_data(sod), .out_update(sod_u));
  always #5 clock = ~clock;
  task automatic tick(); @(posedge clock); #1; endtask
  task automatic want(input string tag, input logic [63:0] v); sb.push_back('{tag, v}); endtask
  task automatic got(input logic [63:0] o);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      errs++;
      $error("FAIL sb_empty: observed %h, nothing expected", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) else begin errs++; $error("FAIL %s: observed %h expected %h", e.tag, o, e.v); end
    end
  endtask
  initial begin
    ra = 10; rb = 8;
    #1 ctrl_reset = 1;
    #2 want("rst_rd", 0); got(64'(rda));
    want("rst_od", 0); got(64'(od));
    want("rst_upd", 0); got(64'(od_u));
    tick(); tick(); ctrl_reset = 0;
    // write then asynchronous reset mid-cycle
    we = 1; wa = 10; wd = 32'h1234; tick(); we = 0;
    want("wr10", 64'h1234); got(64'(rda));
    #2 ctrl_reset = 1; #1;
    want("async_rst_rd", 0); got(64'(rda));
    want("async_rst_edge", 0); got(64'(rdb));
    #1 ctrl_reset = 0;
    we = 1; wa = 4; wd = 32'h99; ctrl_reset = 1; tick(); ctrl_reset = 0; we = 0;
    want("rst_discard_upd", 0); got(64'(od_u));
    want("rst_discard_od", 0); got(64'(od));
    // input channel 1 latency and edge flag
    in_raw = 3'b010; ra = 2; rb = 8;
    tick(); want("in_e0", 0); got(64'(rda)); want("edge_e0", 0); got(64'(rdb));
    tick(); want("in_e1", 1); got(64'(rda)); want("edge_e1", 0); got(64'(rdb));
    tick(); want("edge_e2", 2); got(64'(rdb));
    tick(); want("edge_held", 2); got(64'(rdb));
    in_raw = 3'b011; tick(); tick(); tick();
    want("edge_both", 3); got(64'(rdb));
    // W1C and set-wins
    we = 1; wa = 8; wd = 1; tick(); we = 0;
    want("w1c_bit0", 2); got(64'(rdb));
    in_raw = 3'b001; tick(); tick(); tick();
    want("edge_after_fall", 2); got(64'(rdb));
    in_raw = 3'b011; tick(); tick();
    we = 1; wa = 8; wd = 2; tick(); we = 0;
    want("set_wins", 2); got(64'(rdb));
    we = 1; wa = 8; wd = 2; tick(); we = 0;
    want("w1c_bit1", 0); got(64'(rdb));
    // output channel
    we = 1; wa = 4; wd = 32'h50; tick();
    want("out_data", 64'h50); got(64'(od)); want("out_upd", 1); got(64'(od_u));
    tick(); want("out_upd_again", 1); got(64'(od_u));
    we = 0; tick();
    want("out_upd_off", 0); got(64'(od_u)); want("out_hold", 64'h50); got(64'(od));
    // bypass vs no bypass
    ra = 7; we = 1; wa = 7; wd = 32'hABCD; #1;
    want("bypass", 64'hABCD); got(64'(rda));
    want("no_bypass_old", 0); got(64'(nba));
    tick(); we = 0;
    want("no_bypass_new", 64'hABCD); got(64'(nba));
    // protected addresses
    we = 1; wa = 0; wd = 32'hFFFF; ra = 0; rb = 1; #1;
    want("zero_bypass", 0); got(64'(rda));
    tick(); wa = 1; #1;
    want("in_no_bypass", 1); got(64'(rdb));
    tick(); we = 0;
    want("zero_rd", 0); got(64'(rda));
    want("in_protected", 1); got(64'(rdb));
    // parameter sweep instance
    we = 1; wa = 12; wd = 32'h1111; tick();
    want("sw_upd0", 64'b001); got(64'(sod_u));
    want("sw_od0", 64'h1111); got(64'(sod));
    wa = 13; wd = 32'h2222; tick();
    want("sw_upd1", 64'b010); got(64'(sod_u));
    wa = 14; wd = 32'h3333; tick();
    want("sw_upd2", 64'b100); got(64'(sod_u));
    want("sw_od_all", 64'h3333_2222_1111); got(64'(sod));
    we = 0; tick();
    want("sw_upd_off", 0); got(64'(sod_u));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
